// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared constants and types for the mux4_rr_sched scheduler.
//            - NUM_CH / CH_W        : channel count and channel-index width
//            - BURST_MAX_MIN / _LIM : legal range of the BURST_MAX parameter
//            - BURST_CNT_W          : width of the optional burst counter
//            - state_t              : two-state scheduler FSM encoding
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int NUM_CH        = 4;
    localparam int CH_W          = 2;
    localparam int BURST_MAX_MIN = 1;
    localparam int BURST_MAX_LIM = 15;
    localparam int BURST_CNT_W   = 4;

    // IDLE: output register empty. HOLD: output register holds a transfer.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Purpose  : Combinational round-robin search. Finds the first requesting
//            channel in the order ptr, ptr+1, ptr+2, ptr+3 (modulo 4).
// Ports    : req   [3:0] in  - per-channel request
//            ptr   [1:0] in  - highest-priority channel
//            found       out - at least one request present
//            idx   [1:0] out - winning channel (ptr when nothing requests)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              found,
    output logic [CH_W-1:0]   idx
);

    always_comb begin
        found = |req;
        idx   = ptr;
        // Walk from the lowest priority up so the highest-priority hit
        // is the last assignment and therefore wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[ptr + CH_W'(k)]) begin
                idx = ptr + CH_W'(k);
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux4_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_sched
// Purpose  : Round-robin scheduler in front of a 4:1 mux. Arbitrates four
//            request lines, captures the winner's data slice into an output
//            register and presents it downstream with valid/ready.
// Macro    : RR_LOCK_EN - when defined, a granted channel that keeps
//            requesting is served up to BURST_MAX times in a row.
// Ports    : clk                  in  - clock, rising edge
//            rst                  in  - asynchronous active-high reset
//            req   [3:0]          in  - per-channel request
//            in    [4*DATA_W-1:0] in  - channel data, ch i at i*DATA_W
//            ack   [3:0]          out - one-hot capture strobe (comb.)
//            sel   [1:0]          out - registered select of held channel
//            out   [DATA_W-1:0]   out - captured data
//            out_ch[1:0]          out - channel index of out
//            out_valid            out - out/out_ch hold a pending transfer
//            out_ready            in  - downstream accepts the transfer
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_sched
    import mux_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*DATA_W-1:0] in,
    output logic [NUM_CH-1:0]        ack,
    output logic [CH_W-1:0]          sel,
    output logic [DATA_W-1:0]        out,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    if ((BURST_MAX < BURST_MAX_MIN) || (BURST_MAX > BURST_MAX_LIM)) begin : g_burst_range
        $error("mux4_rr_sched: BURST_MAX out of legal range");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_ptr;
    logic [CH_W-1:0]     w_ptr_nxt;
    logic [CH_W-1:0]     r_sel;
    logic [CH_W-1:0]     w_sel_nxt;
    logic [DATA_W-1:0]   r_out;
    logic [DATA_W-1:0]   w_out_nxt;

    logic                w_hs;
    logic                w_lock;
    logic [CH_W-1:0]     w_rot_ptr;
    logic [CH_W-1:0]     w_ptr_eff;
    logic                w_found;
    logic [CH_W-1:0]     w_pick_idx;
    logic [CH_W-1:0]     w_idx;
    logic                w_load;
    logic [DATA_W-1:0]   w_data;

    assign w_hs      = (r_state == HOLD) && out_ready;
    assign w_rot_ptr = r_sel + 2'd1;

`ifdef RR_LOCK_EN
    localparam logic [BURST_CNT_W:0] c_burst = (BURST_CNT_W + 1)'(BURST_MAX);

    logic [BURST_CNT_W-1:0] r_cnt;
    logic [BURST_CNT_W-1:0] w_cnt_nxt;

    // Stay on the current channel while it still requests and the burst
    // budget is not yet used up.
    assign w_lock = w_hs && req[r_sel] &&
                    (({1'b0, r_cnt} + (BURST_CNT_W + 1)'(1)) < c_burst);
`else
    assign w_lock = 1'b0;
`endif

    // A handshake rotates the pointer in the same cycle, so the search for
    // the next winner already starts after the channel just served.
    assign w_ptr_eff = w_hs ? w_rot_ptr : r_ptr;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (w_ptr_eff),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    assign w_idx  = w_lock ? r_sel : w_pick_idx;
    assign w_load = w_found && ((r_state == IDLE) || out_ready);

    // 4:1 data select slice feeding the output register.
    always_comb begin
        w_data = in[0 +: DATA_W];
        case (w_idx)
            2'd0: w_data = in[0 * DATA_W +: DATA_W];
            2'd1: w_data = in[1 * DATA_W +: DATA_W];
            2'd2: w_data = in[2 * DATA_W +: DATA_W];
            2'd3: w_data = in[3 * DATA_W +: DATA_W];
        endcase
    end

    // ack is combinational; forced low while reset is held.
    assign ack = (w_load && !rst) ? (4'b0001 << w_idx) : 4'b0000;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_out_nxt   = r_out;
`ifdef RR_LOCK_EN
        w_cnt_nxt   = r_cnt;
`endif
        if (w_hs && !w_lock) begin
            w_ptr_nxt = w_rot_ptr;
        end
        if (w_load) begin
            w_state_nxt = HOLD;
            w_sel_nxt   = w_idx;
            w_out_nxt   = w_data;
`ifdef RR_LOCK_EN
            w_cnt_nxt   = w_lock ? (r_cnt + BURST_CNT_W'(1)) : '0;
`endif
        end else if (w_hs) begin
            // Handshake with nothing to reload: drain to IDLE, sel keeps value.
            w_state_nxt = IDLE;
`ifdef RR_LOCK_EN
            w_cnt_nxt   = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_out   <= '0;
`ifdef RR_LOCK_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_out   <= w_out_nxt;
`ifdef RR_LOCK_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign sel       = r_sel;
    assign out_ch    = r_sel;
    assign out       = r_out;
    assign out_valid = (r_state == HOLD);

endmodule : mux4_rr_sched
`default_nettype wire

// File: tb/tb_mux4_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_sched
// Purpose  : Self-checking bench for mux4_rr_sched. A reference model
//            predicts ack and pushes each expected capture into a queue;
//            the queue is popped and compared when the output handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_sched;

    localparam int DW = 4;
`ifdef RR_LOCK_EN
    localparam int BM = 3;
`else
    localparam int BM = 4;
`endif

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [4*DW-1:0] din;
    logic [3:0]    ack;
    logic [1:0]    sel;
    logic [DW-1:0] out;
    logic [1:0]    out_ch;
    logic          out_valid;
    logic          out_ready;

    mux4_rr_sched #(.DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in        (din),
        .ack       (ack),
        .sel       (sel),
        .out       (out),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] data;
    } item_t;

    item_t sb[$];
    item_t exp_item;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic       m_valid;
    logic [1:0] m_ptr;
    logic [1:0] m_sel;
    int         m_cnt;
    logic       m_hs;
    logic       m_load;
    logic       m_lock;
    logic [1:0] m_idx;
    logic [3:0] m_ack;

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 2'd0;
        m_sel   = 2'd0;
        m_cnt   = 0;
        sb.delete();
    endtask

    task automatic model_eval();
        logic [1:0] p;
        bit         done;
        m_hs   = m_valid && out_ready;
        m_lock = 1'b0;
`ifdef RR_LOCK_EN
        m_lock = m_hs && req[m_sel] && ((m_cnt + 1) < BM);
`endif
        p      = m_hs ? (m_sel + 2'd1) : m_ptr;
        m_load = (req != 4'b0) && (!m_valid || out_ready);
        m_idx  = p;
        done   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (int'(p) + k) % 4;
            if (!done && req[c]) begin
                m_idx = 2'(c);
                done  = 1'b1;
            end
        end
        if (m_lock) m_idx = m_sel;
        m_ack = m_load ? (4'b0001 << m_idx) : 4'b0000;
    endtask

    task automatic model_commit();
        item_t it;
        if (m_hs && !m_lock) m_ptr = m_sel + 2'd1;
        if (m_load) begin
            it.ch   = m_idx;
            it.data = din[int'(m_idx) * DW +: DW];
            sb.push_back(it);
            m_sel   = m_idx;
            m_valid = 1'b1;
            m_cnt   = m_lock ? (m_cnt + 1) : 0;
        end else if (m_hs) begin
            m_valid = 1'b0;
            m_cnt   = 0;
        end
    endtask

    // Advance one clock: model follows the edge, inputs may change at +1.
    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // Empty the output register without checking (between scenarios).
    task automatic drain();
        req       = 4'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            model_eval();
            if (m_hs && sb.size() > 0) exp_item = sb.pop_front();
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        total++; if (sel !== 2'd0) begin bad++; $display("FAIL rst_sel: got %0d expected 0", sel); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL rst_out_ch: got %0d expected 0", out_ch); end
        total++; if (out !== '0) begin bad++; $display("FAIL rst_out: got %h expected 0", out); end
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL rst_ack: got %b expected 0000", ack); end
        req = 4'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fairness();
        out_ready = 1'b1;
        req       = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            din = 16'($urandom);
            @(negedge clk);
            model_eval();
            total++; if (ack !== m_ack) begin bad++; $display("FAIL fair_ack[%0d]: got %b expected %b", i, ack, m_ack); end
`ifndef RR_LOCK_EN
            total++; if (ack !== (4'b0001 << (i % 4))) begin bad++; $display("FAIL fair_order[%0d]: got %b expected ch %0d", i, ack, i % 4); end
`endif
            total++; if (out_valid !== m_valid) begin bad++; $display("FAIL fair_valid[%0d]: got %b expected %b", i, out_valid, m_valid); end
            if (m_hs) begin
                exp_item = sb.pop_front();
                total++; if ({out_ch, out} !== {exp_item.ch, exp_item.data}) begin bad++; $display("FAIL fair_data[%0d]: got ch%0d/%h expected ch%0d/%h", i, out_ch, out, exp_item.ch, exp_item.data); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_single();
        din       = 16'hA1C3;
        req       = 4'b0100;
        out_ready = 1'b1;
        @(negedge clk);
        model_eval();
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL single_ack: got %b expected 0100", ack); end
        tick();
        req = 4'b0000;
        @(negedge clk);
        model_eval();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        total++; if (out_ch !== 2'd2 || sel !== 2'd2) begin bad++; $display("FAIL single_ch: got out_ch %0d sel %0d expected 2", out_ch, sel); end
        total++; if (out !== 4'h1) begin bad++; $display("FAIL single_out: got %h expected 1", out); end
        exp_item = sb.pop_front();
        total++; if ({out_ch, out} !== {exp_item.ch, exp_item.data}) begin bad++; $display("FAIL single_sb: got ch%0d/%h expected ch%0d/%h", out_ch, out, exp_item.ch, exp_item.data); end
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL single_ack_idle: got %b expected 0000", ack); end
        tick();
    endtask

    // Entered with ptr=3 (last served channel was 2).
    task automatic test_wrap_skip();
        out_ready = 1'b1;
        req       = 4'b0010;
        din       = 16'h4321;
        @(negedge clk);
        model_eval();
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL wrap_ack: got %b expected 0010", ack); end
        tick();
        req = 4'b1101;
        @(negedge clk);
        model_eval();
        total++; if (out_ch !== 2'd1 || out !== 4'h2) begin bad++; $display("FAIL wrap_out: got ch%0d/%h expected ch1/2", out_ch, out); end
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL skip_ack: got %b expected 0100", ack); end
        exp_item = sb.pop_front();
        tick();
        req = 4'b0000;
        @(negedge clk);
        model_eval();
        total++; if (out_ch !== 2'd2 || out !== 4'h3) begin bad++; $display("FAIL skip_out: got ch%0d/%h expected ch2/3", out_ch, out); end
        exp_item = sb.pop_front();
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        req       = 4'b1000;
        din       = 16'h5000;
        @(negedge clk);
        model_eval();
        total++; if (ack !== 4'b1000) begin bad++; $display("FAIL bp_load_ack: got %b expected 1000", ack); end
        tick();
        for (int i = 0; i < 5; i++) begin
            req = 4'($urandom);
            din = 16'($urandom);
            @(negedge clk);
            model_eval();
            total++; if (ack !== 4'b0) begin bad++; $display("FAIL bp_ack[%0d]: got %b expected 0000", i, ack); end
            total++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out !== 4'h5) begin bad++; $display("FAIL bp_hold[%0d]: got v%b ch%0d/%h expected v1 ch3/5", i, out_valid, out_ch, out); end
            tick();
        end
        req       = 4'b0;
        out_ready = 1'b1;
        @(negedge clk);
        model_eval();
        exp_item = sb.pop_front();
        total++; if ({out_valid, out_ch, out} !== {1'b1, exp_item.ch, exp_item.data}) begin bad++; $display("FAIL bp_release: got v%b ch%0d/%h expected v1 ch%0d/%h", out_valid, out_ch, out, exp_item.ch, exp_item.data); end
        tick();
        @(negedge clk);
        model_eval();
        total++; if (out_valid !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL bp_after: got v%b ack %b expected v0 ack 0000", out_valid, ack); end
        total++; if (sel !== 2'd3) begin bad++; $display("FAIL bp_sel_keep: got %0d expected 3", sel); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            req       = 4'($urandom);
            din       = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_eval();
            total++; if (ack !== m_ack) begin bad++; $display("FAIL rnd_ack[%0d]: got %b expected %b", i, ack, m_ack); end
            total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, m_valid); end
            if (m_valid && sb.size() > 0) begin
                exp_item = m_hs ? sb.pop_front() : sb[0];
                total++; if ({out_ch, out} !== {exp_item.ch, exp_item.data}) begin bad++; $display("FAIL rnd_data[%0d]: got ch%0d/%h expected ch%0d/%h", i, out_ch, out, exp_item.ch, exp_item.data); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        req       = 4'b0100;
        din       = 16'h0900;
        tick();
        req = 4'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_ch !== 2'd2) begin bad++; $display("FAIL rmid_pre: got v%b ch%0d expected v1 ch2", out_valid, out_ch); end
        #1 rst = 1'b1;
        #1;
        total++; if ({out_valid, out_ch, sel, out, ack} !== '0) begin bad++; $display("FAIL rmid_async: got v%b ch%0d sel%0d out %h ack %b expected all 0", out_valid, out_ch, sel, out, ack); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        model_eval();
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL rmid_ptr0: got %b expected 0001", ack); end
        tick();
        drain();
    endtask

`ifdef RR_LOCK_EN
    task automatic test_lock();
        logic [1:0] seq [7];
        seq = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        req       = 4'b0011;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            din = 16'($urandom);
            @(negedge clk);
            model_eval();
            total++; if (ack !== (4'b0001 << seq[i])) begin bad++; $display("FAIL lock_seq[%0d]: got %b expected ch %0d", i, ack, seq[i]); end
            if (m_hs) begin
                exp_item = sb.pop_front();
                total++; if ({out_ch, out} !== {exp_item.ch, exp_item.data}) begin bad++; $display("FAIL lock_data[%0d]: got ch%0d/%h expected ch%0d/%h", i, out_ch, out, exp_item.ch, exp_item.data); end
            end
            tick();
        end
        drain();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req       = 4'b0;
        din       = '0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_fairness();
        test_single();
        test_wrap_skip();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef RR_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mux4_rr_sched
`default_nettype wire

// File: doc/mux4_rr_sched.md
# mux4_rr_sched

Round-robin scheduler that sits directly upstream of the team's 4:1 multiplexers. It arbitrates among four requesting channels and drives the 2-bit select. It captures the selected channel's data through a 4:1 select slice into an output register, and presents the result to the downstream consumer with a valid/ready handshake. It turns four independent request lines into one fair, serialized stream, tagged with the channel index.

## Interface
Parameters:
- DATA_W, 1: width of each channel's data slice.
- BURST_MAX, 4: maximum consecutive transfers per grant. Used only when RR_LOCK_EN is defined; legal range 1..15.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-channel request, bit i = channel i has data.
- in  input  4*DATA_W  channel data, channel i at in[i*DATA_W +: DATA_W].
- ack  output  4  one-hot; high in the cycle channel i's data is captured.
- sel  output  2  registered select of the channel currently held.
- out  output  DATA_W  captured data.
- out_ch  output  2  channel index of out (equals sel).
- out_valid  output  1  out/out_ch hold a pending transfer.
- out_ready  input  1  downstream accepts the transfer when high with out_valid.

## Operation
- Two-state FSM: IDLE (no pending data) and HOLD (output register full).
- ptr[1:0] holds the highest-priority channel. Priority order is ptr, ptr+1, ptr+2, ptr+3, modulo 4 (wraps 3->0).
- A load occurs on an edge when either condition holds:
  - the state is IDLE and any req bit is high, or
  - the state is HOLD, out_ready=1, and any req bit is high.
- At a load:
  - Pick the first requesting channel c in priority order.
  - Register sel=out_ch=c and out=in[c slice].
  - Set out_valid=1 and go to HOLD.
  - ack[c] is combinationally high in that cycle; all other ack bits are 0.
- On a handshake (out_valid & out_ready), ptr becomes c+1. The load decision in that same cycle uses the updated ptr, so ack is computed against the new ptr.
- HOLD with out_ready=0: out, out_ch, sel and out_valid hold stable. ack=0. req changes are ignored.
- HOLD, out_ready=1, req=0: out_valid falls and the FSM goes to IDLE. sel keeps its last value.
- out_ready while out_valid=0 is ignored.
- Upstream channels must treat ack[i] as a consume strobe: drop req[i] or present the next data by the following edge.

## Timing
- Reset values:
  - state=IDLE, ptr=0.
  - sel=0, out_ch=0, out=0, out_valid=0.
  - ack=0 (ack is combinational, so it is 0 whenever the state is IDLE with req=0 or during reset).
- Reset mid-transfer discards the held data. No ack is reissued.
- Latency: req rising before edge N gives out_valid=1 after edge N (one cycle).
- Throughput: one transfer per cycle while out_ready=1 and at least one req bit is high (back-to-back, no bubble).
- Fairness: with all four req bits held high and out_ready=1, channels are served 0,1,2,3,0,... (with RR_LOCK_EN off).
- Sampling: in is sampled only on the load edge. Later changes to in do not affect out.

## Configuration
- RR_LOCK_EN defined:
  - A burst counter (4 bits, reset 0) is added.
  - On a handshake, if req[c] is still high and count+1 < BURST_MAX, channel c is reloaded, ptr is unchanged and the counter increments.
  - Otherwise the scheduler rotates normally and the counter clears.
  - The counter also clears on entry to IDLE and on reset.
  - BURST_MAX=1 is equivalent to no locking.
- RR_LOCK_EN undefined: no counter is built. The scheduler always rotates after each handshake and BURST_MAX is ignored.

## Structure
- Package mux_pkg holds:
  - localparam NUM_CH=4 and CH_W=2;
  - the state typedef (IDLE, HOLD);
  - the BURST_MAX legal-range constant.
- Sub-module rr_pick4 is a combinational block:
  - inputs req[3:0] and ptr[1:0];
  - outputs found and idx[1:0].
  - It is instantiated once.
- The data capture is a 4:1 select on idx, feeding the out register.

## Test plan
- Reset: assert rst mid-HOLD with out_valid=1 and out_ch=2 -> all outputs 0 asynchronously; after release, ptr=0.
- Single request: req=4'b0100, in[2]=1, DATA_W=1 -> ack=4'b0100 on the load cycle; next cycle out_valid=1, out_ch=2, out=1.
- Fairness: req=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
- Backpressure: out_ready=0 for 5 cycles with req and in toggling -> out, out_ch and out_valid constant and ack=0 throughout; one transfer on release.
- Wrap and skip: ptr=3, req=4'b0010 -> channel 1 granted; the next grant search starts at channel 2.
- RR_LOCK_EN, BURST_MAX=3: req=4'b0011 held, out_ready=1 -> out_ch sequence 0,0,0,1,1,1,0.
